// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic M_WALK  = 1'b0;
    localparam logic M_CACHE = 1'b1;

    // Replicated to DATA_WIDTH to form the read data returned on a watchdog abort.
    localparam logic TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Cycle counter with enable and clear; pulses expired on the cycle the count
// would reach TERMINAL. TERMINAL of 0 disables expiry.
module arb_watchdog #(
    parameter int TERMINAL = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int W = (TERMINAL < 2) ? 1 : $clog2(TERMINAL);
    localparam logic [W-1:0] LAST = (TERMINAL == 0) ? '0 : W'(TERMINAL - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = (TERMINAL != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 4-phase memory port between the page walker
// (master 0) and the L1 fill/writeback path (master 1).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  REQ0,
    input  logic                  REQ1,
    output logic                  ACK0,
    output logic                  ACK1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] ADDR0,
    input  logic [ADDR_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic                  MEM_Request,
    input  logic                  MEM_ACK,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_Address,
    output logic [DATA_WIDTH-1:0] MEM_WData,
    input  logic [DATA_WIDTH-1:0] MEM_RData,
    output logic [CNT_WIDTH-1:0]  Grant_Count0,
    output logic [CNT_WIDTH-1:0]  Grant_Count1,
    output logic                  Timeout_Error
);

    localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{TIMEOUT_FILL}};

    arb_state_t state;
    logic       ptr;
    logic       cur;
    logic       sel;
    logic       req_cur;
    logic       wd_en;
    logic       wd_clr;
    logic       wd_expired;

    // Lone requester wins outright; the pointer only matters under contention.
    assign sel     = (REQ0 && REQ1) ? ptr : REQ1;
    assign req_cur = (cur == M_CACHE) ? REQ1 : REQ0;
    assign wd_en   = (state == ISSUE) && !MEM_ACK;
    assign wd_clr  = (state == DONE) && !req_cur;

    arb_watchdog #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (reset),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= M_WALK;
            cur           <= M_WALK;
            ACK0          <= 1'b0;
            ACK1          <= 1'b0;
            RDATA0        <= '0;
            RDATA1        <= '0;
            MEM_Request   <= 1'b0;
            MEM_WE        <= 1'b0;
            MEM_Address   <= '0;
            MEM_WData     <= '0;
            Grant_Count0  <= '0;
            Grant_Count1  <= '0;
            Timeout_Error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!MEM_ACK && (REQ0 || REQ1)) begin
                        cur         <= sel;
                        MEM_WE      <= (sel == M_CACHE) ? WE1    : WE0;
                        MEM_Address <= (sel == M_CACHE) ? ADDR1  : ADDR0;
                        MEM_WData   <= (sel == M_CACHE) ? WDATA1 : WDATA0;
                        MEM_Request <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A memory ack on the expiry cycle still completes normally.
                    if (MEM_ACK) begin
                        if (!MEM_WE) begin
                            if (cur == M_CACHE) RDATA1 <= MEM_RData;
                            else                RDATA0 <= MEM_RData;
                        end
                        MEM_Request <= 1'b0;
                        state       <= DRAIN;
                    end else if (wd_expired) begin
                        Timeout_Error <= 1'b1;
                        if (cur == M_CACHE) RDATA1 <= FILL;
                        else                RDATA0 <= FILL;
                        MEM_Request <= 1'b0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!MEM_ACK) begin
                        ACK0  <= (cur == M_WALK);
                        ACK1  <= (cur == M_CACHE);
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!req_cur) begin
                        ACK0 <= 1'b0;
                        ACK1 <= 1'b0;
                        if (cur == M_CACHE) Grant_Count1 <= Grant_Count1 + 1'b1;
                        else                Grant_Count0 <= Grant_Count0 + 1'b1;
                        ptr   <= (cur == M_WALK) ? M_CACHE : M_WALK;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single-master
// transactions plus hand sequences for contention, timeout and reset corners.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          REQ0, REQ1, ACK0, ACK1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1, RDATA0, RDATA1;
    logic          MEM_Request, MEM_ACK, MEM_WE;
    logic [AW-1:0] MEM_Address;
    logic [DW-1:0] MEM_WData, MEM_RData;
    logic [CW-1:0] Grant_Count0, Grant_Count1;
    logic          Timeout_Error;

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .REQ0          (REQ0),
        .REQ1          (REQ1),
        .ACK0          (ACK0),
        .ACK1          (ACK1),
        .WE0           (WE0),
        .WE1           (WE1),
        .ADDR0         (ADDR0),
        .ADDR1         (ADDR1),
        .WDATA0        (WDATA0),
        .WDATA1        (WDATA1),
        .RDATA0        (RDATA0),
        .RDATA1        (RDATA1),
        .MEM_Request   (MEM_Request),
        .MEM_ACK       (MEM_ACK),
        .MEM_WE        (MEM_WE),
        .MEM_Address   (MEM_Address),
        .MEM_WData     (MEM_WData),
        .MEM_RData     (MEM_RData),
        .Grant_Count0  (Grant_Count0),
        .Grant_Count1  (Grant_Count1),
        .Timeout_Error (Timeout_Error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory responder: raises MEM_ACK mem_delay cycles after seeing a request,
    // drops it once the request falls.
    logic mem_en    = 1'b0;
    int   mem_delay = 1;
    int   dly_cnt   = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                if (MEM_Request && !MEM_ACK) begin
                    if (dly_cnt + 1 >= mem_delay) MEM_ACK = 1'b1;
                    else                          dly_cnt++;
                end else if (!MEM_Request && MEM_ACK) begin
                    MEM_ACK = 1'b0;
                    dly_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_memreq(input logic level, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (MEM_Request === level) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_ack(input logic m, input logic level, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((m ? ACK1 : ACK0) === level) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic set_req(input logic m, input logic v);
        if (m) REQ1 = v;
        else   REQ0 = v;
    endtask

    // Full 4-phase handshake for one master against the responder.
    task automatic txn(input logic m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mrdata, input int dly);
        logic ok;
        mem_en    = 1'b1;
        mem_delay = dly;
        MEM_RData = mrdata;
        if (m) begin WE1 = we; ADDR1 = addr; WDATA1 = wdata; end
        else   begin WE0 = we; ADDR0 = addr; WDATA0 = wdata; end
        set_req(m, 1'b1);
        wait_memreq(1'b1, ok);
        chk("txn mem_req rise", ok, 1);
        chk("txn mem_addr", MEM_Address, addr);
        chk("txn mem_we", MEM_WE, we);
        if (we) chk("txn mem_wdata", MEM_WData, wdata);
        wait_ack(m, 1'b1, ok);
        chk("txn ack rise", ok, 1);
        chk("txn other ack low", m ? ACK0 : ACK1, 0);
        set_req(m, 1'b0);
        wait_ack(m, 1'b0, ok);
        chk("txn ack fall", ok, 1);
        tick();
    endtask

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int          dly;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } vec_t;

    vec_t vecs[5];
    int   exp_cnt[2];

    initial begin
        logic ok;
        logic g;
        int   n;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,          32'h0000_2000, 2, 32'h0000_2000, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 32'h1111_1111, 2, 32'h0000_2000, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          32'h1234_5678, 1, 32'h0000_2000, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_5A5A, 32'h7777_7777, 3, 32'h0000_2000, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_FFFC, 32'h0,          32'hCAFE_F00D, 1, 32'hCAFE_F00D, 32'h1234_5678};

        reset = 1'b1;
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
        MEM_ACK = 0; MEM_RData = 0;
        repeat (3) tick();
        chk("rst mem_req", MEM_Request, 0);
        chk("rst acks", {ACK0, ACK1}, 0);
        chk("rst rdata0", RDATA0, 0);
        chk("rst counts", {Grant_Count0, Grant_Count1}, 0);
        chk("rst timeout", Timeout_Error, 0);
        reset = 1'b0;
        tick();

        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        foreach (vecs[i]) begin
            txn(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mrdata, vecs[i].dly);
            exp_cnt[vecs[i].m]++;
            chk($sformatf("vec%0d rdata0", i), RDATA0, vecs[i].exp_rd0);
            chk($sformatf("vec%0d rdata1", i), RDATA1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d count0", i), Grant_Count0, exp_cnt[0]);
            chk($sformatf("vec%0d count1", i), Grant_Count1, exp_cnt[1]);
        end

        // Pointer now favours master 1; reset must bring it back to master 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2 counts", {Grant_Count0, Grant_Count1}, 0);
        tick();

        mem_en = 1'b1; mem_delay = 1;
        WE0 = 0; WE1 = 0;
        REQ0 = 1; REQ1 = 1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!(ACK0 || ACK1) && n < 64) begin tick(); n++; end
            chk($sformatf("rr%0d ack seen", i), (ACK0 || ACK1), 1);
            chk($sformatf("rr%0d one ack", i), (ACK0 && ACK1), 0);
            g = ACK1;
            chk($sformatf("rr%0d grant", i), g, i % 2);
            set_req(g, 1'b0);
            wait_ack(g, 1'b0, ok);
            chk($sformatf("rr%0d ack fall", i), ok, 1);
            if (i == 2) chk("rr counts after 3", {Grant_Count0, Grant_Count1}, {32'd2, 32'd1});
            if (i < 5) set_req(g, 1'b1);
        end
        REQ0 = 0; REQ1 = 0;
        tick();
        chk("rr counts after 6", {Grant_Count0, Grant_Count1}, {32'd3, 32'd3});

        // Watchdog: memory never answers.
        mem_en = 1'b0; MEM_ACK = 0;
        WE0 = 0; ADDR0 = 32'h300;
        REQ0 = 1;
        wait_memreq(1'b1, ok);
        chk("to mem_req rise", ok, 1);
        n = 0;
        while (MEM_Request && n < 20) begin tick(); n++; end
        chk("to issue cycles", n, 8);
        wait_ack(1'b0, 1'b1, ok);
        chk("to ack0 rise", ok, 1);
        chk("to rdata0 fill", RDATA0, 32'hFFFF_FFFF);
        chk("to flag", Timeout_Error, 1);
        REQ0 = 0;
        wait_ack(1'b0, 1'b0, ok);
        chk("to ack0 fall", ok, 1);
        chk("to counted", Grant_Count0, 4);
        tick();
        txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 1);
        chk("to flag sticky", Timeout_Error, 1);
        chk("to next rdata1", RDATA1, 32'h0BAD_F00D);

        // Asynchronous reset in the middle of ISSUE.
        mem_en = 1'b0; MEM_ACK = 0;
        ADDR0 = 32'h700; REQ0 = 1;
        wait_memreq(1'b1, ok);
        chk("ar mem_req rise", ok, 1);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("ar mem_req drop", MEM_Request, 0);
        chk("ar acks", {ACK0, ACK1}, 0);
        chk("ar counts", {Grant_Count0, Grant_Count1}, 0);
        chk("ar timeout cleared", Timeout_Error, 0);
        REQ0 = 0;
        tick();
        reset = 1'b0;
        txn(1'b1, 1'b0, 32'h0000_0A0C, 32'h0, 32'h5555_AAAA, 1);
        chk("ar m1 rdata", RDATA1, 32'h5555_AAAA);
        chk("ar counts after", {Grant_Count0, Grant_Count1}, {32'd0, 32'd1});

        // No issue while memory still holds ACK.
        mem_en = 1'b0;
        MEM_ACK = 1; ADDR0 = 32'h0000_0B00; WE0 = 0; REQ0 = 1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (MEM_Request) n++;
        end
        chk("ackhi held off", n, 0);
        MEM_ACK = 0;
        tick();
        chk("ackhi issue next edge", MEM_Request, 1);
        chk("ackhi addr", MEM_Address, 32'h0000_0B00);
        mem_en = 1'b1; mem_delay = 1; MEM_RData = 32'h0000_0BBB;
        wait_ack(1'b0, 1'b1, ok);
        chk("ackhi ack0", ok, 1);
        REQ0 = 0;
        wait_ack(1'b0, 1'b0, ok);
        chk("ackhi rdata0", RDATA0, 32'h0000_0BBB);
        tick();

        // Master withdraws request before ACK: one-cycle ACK pulse, still counted.
        WE1 = 1; ADDR1 = 32'h0000_0C00; WDATA1 = 32'h0000_1234; mem_delay = 3;
        REQ1 = 1;
        wait_memreq(1'b1, ok);
        chk("early mem_req", ok, 1);
        REQ1 = 0;
        wait_ack(1'b1, 1'b1, ok);
        chk("early ack1 rise", ok, 1);
        tick();
        chk("early ack1 pulse", ACK1, 0);
        chk("early counted", Grant_Count1, 2);
        chk("early rdata1 kept", RDATA1, 32'h5555_AAAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-master, one-slave arbiter sharing the single physical memory port between the page walker/TLB path (master 0) and the L1 cache fill/writeback path (master 1). Both masters and the memory use the team's 4-phase Request/ACK handshake: request high, ACK high, request low, ACK low. Arbitration is round-robin, one transaction at a time. The block also provides per-master grant counters for the stats report and a sticky memory-timeout flag.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 1024, cycles in ISSUE without MEM_ACK before abort; 0 disables the watchdog
CNT_WIDTH, 32, width of the grant counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
REQ0 / REQ1  in  1  master request
ACK0 / ACK1  out  1  master acknowledge
WE0 / WE1  in  1  1 = write, 0 = read
ADDR0 / ADDR1  in  ADDR_WIDTH  master address
WDATA0 / WDATA1  in  DATA_WIDTH  master write data
RDATA0 / RDATA1  out  DATA_WIDTH  read data returned to the master
MEM_Request  out  1  request to memory
MEM_ACK  in  1  acknowledge from memory
MEM_WE  out  1  write enable to memory
MEM_Address  out  ADDR_WIDTH  address to memory
MEM_WData  out  DATA_WIDTH  write data to memory
MEM_RData  in  DATA_WIDTH  read data from memory
Grant_Count0 / Grant_Count1  out  CNT_WIDTH  completed transactions per master
Timeout_Error  out  1  sticky watchdog flag

Behaviour:
Clock and reset
- One clock: clk.
- reset is asynchronous and active-high.
- While reset is high, all outputs are 0, state is IDLE, the priority pointer is 0 (master 0 favoured) and the watchdog counter is 0.
- Reset mid-transaction drops MEM_Request and ACKx immediately; the abandoned transaction is not counted.

State machine: IDLE, ISSUE, DRAIN, DONE
- IDLE:
  - Stays here while MEM_ACK==1 or both REQ are low.
  - Otherwise selects a master: the only requester if one; the pointer's master if both.
  - Latches that master's WE, ADDR and WDATA into MEM_WE, MEM_Address and MEM_WData.
  - Sets MEM_Request=1 and goes to ISSUE.
  - Latency: MEM_Request rises on the first edge at which REQx is sampled high.
- ISSUE:
  - Holds MEM_* stable and increments the watchdog each cycle.
  - When MEM_ACK is sampled 1: if the transaction is a read, captures MEM_RData into RDATAx; clears MEM_Request; goes to DRAIN.
  - When the watchdog reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): sets Timeout_Error, loads RDATAx with all ones, clears MEM_Request, goes to DRAIN.
- DRAIN:
  - Waits for MEM_ACK sampled 0.
  - Then sets ACKx=1 and goes to DONE.
- DONE:
  - Waits for REQx sampled 0.
  - Then clears ACKx, increments Grant_Countx (wraps modulo 2^CNT_WIDTH), sets the pointer to the other master, clears the watchdog and returns to IDLE.
- Minimum transaction is 4 cycles from grant to return to IDLE, assuming the memory acks in 1 cycle.

Boundary and protocol rules
- Timeout_Error is cleared only by reset. A timed-out transaction still counts as a grant.
- Simultaneous REQ0 and REQ1: the pointer decides; back-to-back contention alternates 0, 1, 0, ...
- The non-granted master's ACK stays 0 and its inputs are ignored until it is granted.
- RDATAx holds its last value between transactions. A write does not update RDATAx.
- If a master drops REQx before ACKx, the memory transaction still completes. ACKx then pulses for exactly one cycle in DONE and the grant is counted.
- A new request is never issued while MEM_ACK is high.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3);
  - the master index constants M_WALK=0 and M_CACHE=1;
  - the timeout fill constant (all ones).
- One sub-module is natural: arb_watchdog. It holds the counter with enable, clear and parameterised terminal count, and outputs an expired pulse.
- All other logic stays in one module.

Test Plan:
- Reset, then REQ0=1, WE0=0, ADDR0=0x00001004; memory acks in 2 cycles with MEM_RData=0x00002000 -> MEM_Address=0x00001004, RDATA0=0x00002000, ACK0 high, Grant_Count0=1.
- REQ0 and REQ1 raised on the same cycle, three times in a row -> grant order 0, 1, 0 after reset (then 1, 0, 1); counts are 2 and 1 after the first three.
- REQ1=1, WE1=1, ADDR1=0x0000A000, WDATA1=0xDEADBEEF -> MEM_WE=1, MEM_WData=0xDEADBEEF; RDATA1 unchanged; ACK1 handshake completes.
- TIMEOUT_CYCLES=8, memory never acks -> MEM_Request drops after 8 ISSUE cycles; RDATA0=0xFFFFFFFF; Timeout_Error=1 and stays 1 through the next good transaction.
- Reset asserted while in ISSUE -> MEM_Request=0, ACK0=0 and counts 0 without waiting for clk; after release, REQ1 is granted first.
- MEM_ACK held high at IDLE with REQ0=1 -> MEM_Request stays 0 until MEM_ACK falls, then rises on the next edge.
